// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-word reads,
// and enqueues returned words with their PC behind a one-entry hold buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        iq_full,
    output logic        iq_write,
    output logic [31:0] iq_data,
    output logic [31:0] iq_pc
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] pc_inc;
    logic [31:0] hold_data;
    logic [31:0] hold_pc;
    logic        hold_load;

    assign pc_inc = pc + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            hold_data <= '0;
            hold_pc   <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            if (hold_load) begin
                hold_data <= imem_rdata;
                hold_pc   <= pc;
            end
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        hold_load  = 1'b0;
        imem_addr  = pc;
        imem_rmask = 4'h0;
        iq_write   = 1'b0;
        iq_data    = '0;
        iq_pc      = '0;
        if (rst) begin
            state_d = IDLE;
        end else if (flush) begin
            // Redirect wins; a request still in flight must be drained in DROP.
            pc_d = {flush_pc[31:2], 2'b00};
            unique case (state)
                WAIT, DROP: state_d = imem_resp ? IDLE : DROP;
                default:    state_d = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (!iq_full) begin
                        imem_rmask = 4'hF;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp && !iq_full) begin
                        iq_write   = 1'b1;
                        iq_data    = imem_rdata;
                        iq_pc      = pc;
                        pc_d       = pc_inc;
                        imem_addr  = pc_inc;
                        imem_rmask = 4'hF;
                    end else if (imem_resp) begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (!iq_full) begin
                        iq_write = 1'b1;
                        iq_data  = hold_data;
                        iq_pc    = hold_pc;
                        pc_d     = pc_inc;
                        state_d  = IDLE;
                    end
                end
                DROP: begin
                    if (imem_resp) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit: per-cycle stimulus and
// expected outputs, plus a zero-wait streaming sequence.
module tb_fetch_unit;

    localparam logic [31:0] R = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        iq_full = 1'b0;
    logic        iq_write;
    logic [31:0] iq_data;
    logic [31:0] iq_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .iq_full    (iq_full),
        .iq_write   (iq_write),
        .iq_data    (iq_data),
        .iq_pc      (iq_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [31:0] fpc;
        logic        full;
        logic        resp;
        logic [31:0] rdata;
        logic        rm;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] ipc;
        logic [31:0] idata;
    } vec_t;

    function automatic logic [31:0] d(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic vec_t v(
        input logic rs, input logic fl, input logic [31:0] fp,
        input logic fu, input logic re, input logic [31:0] rd,
        input logic rm, input logic [31:0] ad,
        input logic wr, input logic [31:0] ip, input logic [31:0] id
    );
        vec_t t;
        t.rst = rs; t.flush = fl; t.fpc = fp;
        t.full = fu; t.resp = re; t.rdata = rd;
        t.rm = rm; t.addr = ad;
        t.wr = wr; t.ipc = ip; t.idata = id;
        return t;
    endfunction

    task automatic chk(
        input string nm, input int idx,
        input logic [31:0] act, input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h",
                     nm, idx, act, exp);
        end
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back(v(1,0,0,0,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,R, 0,0,0));
        tbl.push_back(v(0,0,0,0,1,d(R), 1,R+4, 1,R,d(R)));
        tbl.push_back(v(0,0,0,0,1,d(R+4), 1,R+8, 1,R+4,d(R+4)));
        tbl.push_back(v(0,0,0,1,1,d(R+8), 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 0,0, 1,R+8,d(R+8)));
        tbl.push_back(v(0,0,0,0,0,0, 1,R+12, 0,0,0));
        tbl.push_back(v(0,0,0,0,1,d(R+12), 1,R+16, 1,R+12,d(R+12)));
        tbl.push_back(v(0,1,32'h1000,0,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,1,32'h1000,0,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,1,d(R+16), 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'h1000, 0,0,0));
        tbl.push_back(v(0,0,0,0,1,d(32'h1000), 1,32'h1004,
                        1,32'h1000,d(32'h1000)));
        tbl.push_back(v(0,1,32'hFFFF_FFFC,0,1,d(32'h1004), 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'hFFFF_FFFC, 0,0,0));
        tbl.push_back(v(0,0,0,0,1,d(32'hFFFF_FFFC), 1,32'h0,
                        1,32'hFFFF_FFFC,d(32'hFFFF_FFFC)));
        tbl.push_back(v(0,0,0,0,1,d(32'h0), 1,32'h4, 1,32'h0,d(32'h0)));
        tbl.push_back(v(0,1,32'h1003,0,1,d(32'h4), 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'h1000, 0,0,0));
        tbl.push_back(v(0,0,0,0,1,d(32'h1000), 1,32'h1004,
                        1,32'h1000,d(32'h1000)));
        tbl.push_back(v(0,0,0,0,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,1,1,d(32'h1004), 0,0, 0,0,0));
        tbl.push_back(v(0,1,32'h2000,1,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,1,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'h2000, 0,0,0));
        tbl.push_back(v(1,0,0,0,0,0, 0,0, 0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,R, 0,0,0));
        tbl.push_back(v(0,0,0,0,1,d(R), 1,R+4, 1,R,d(R)));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst        = tbl[i].rst;
            flush      = tbl[i].flush;
            flush_pc   = tbl[i].fpc;
            iq_full    = tbl[i].full;
            imem_resp  = tbl[i].resp;
            imem_rdata = tbl[i].rdata;
            #1;
            chk("rmask", i, {28'h0, imem_rmask}, {28'h0, {4{tbl[i].rm}}});
            if (tbl[i].rm)
                chk("addr", i, imem_addr, tbl[i].addr);
            chk("iq_write", i, {31'h0, iq_write}, {31'h0, tbl[i].wr});
            if (tbl[i].wr || tbl[i].rst) begin
                chk("iq_pc", i, iq_pc, tbl[i].ipc);
                chk("iq_data", i, iq_data, tbl[i].idata);
            end
        end

        // Zero-wait streaming: request for R+4 is already outstanding.
        for (int k = 1; k <= 6; k++) begin
            logic [31:0] a;
            a = R + 32'(4 * k);
            @(negedge clk);
            rst        = 1'b0;
            flush      = 1'b0;
            iq_full    = 1'b0;
            imem_resp  = 1'b1;
            imem_rdata = d(a);
            #1;
            chk("s_write", 100 + k, {31'h0, iq_write}, 32'h1);
            chk("s_pc", 100 + k, iq_pc, a);
            chk("s_data", 100 + k, iq_data, d(a));
            chk("s_addr", 100 + k, imem_addr, a + 32'h4);
            chk("s_rmask", 100 + k, {28'h0, imem_rmask}, 32'hF);
        end

        // Async reset mid-cycle must clear outputs before any clock edge.
        @(negedge clk);
        imem_resp = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_write", 200, {31'h0, iq_write}, 32'h0);
        chk("ar_rmask", 200, {28'h0, imem_rmask}, 32'h0);
        chk("ar_pc", 200, iq_pc, 32'h0);
        chk("ar_data", 200, iq_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_req", 201, {28'h0, imem_rmask}, 32'hF);
        chk("ar_addr", 201, imem_addr, R);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
